// File: rtl/thumb_uart_streamer.sv
// Thumbnail-to-UART streamer: sync header, then WIDTH x HEIGHT words MSB byte first.
// Optional trailing XOR checksum byte when THUMB_STREAMER_CSUM_EN is defined.
module thumb_uart_streamer #(
    parameter int          WIDTH        = 40,
    parameter int          HEIGHT       = 30,
    parameter int          HOLDOFF_BITS = 13,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          SYNC_LEN     = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic        start_i,
    input  logic        continuous_i,
    output logic [5:0]  rd_x_o,
    output logic [4:0]  rd_y_o,
    input  logic [31:0] rd_q_i,
    input  logic        uart_busy_i,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int SCW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
    localparam logic [5:0]     X_LAST = 6'(WIDTH - 1);
    localparam logic [4:0]     Y_LAST = 5'(HEIGHT - 1);
    localparam logic [SCW-1:0] S_LAST = SCW'(SYNC_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_FETCH,
        S_LOAD,
        S_SEND,
`ifdef THUMB_STREAMER_CSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [HOLDOFF_BITS-1:0] holdoff_q;
    logic [HOLDOFF_BITS-1:0] holdoff_d;
    logic                    send_ok;
    logic [5:0]              x_q;
    logic [4:0]              y_q;
    logic [31:0]             word_q;
    logic [1:0]              idx_q;
    logic [SCW-1:0]          sync_q;
    logic                    wr_q;
    logic [7:0]              dat_q;
    logic                    busy_q;
    logic                    done_q;
    logic [7:0]              pix_byte;
`ifdef THUMB_STREAMER_CSUM_EN
    logic [7:0]              csum_q;
`endif

    assign rd_x_o       = x_q;
    assign rd_y_o       = y_q;
    assign uart_wr_o    = wr_q;
    assign uart_dat_o   = dat_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

    // Idle-gap counter, byte select and the send permission.
    always_comb begin
        holdoff_d = holdoff_q;
        if (uart_busy_i || wr_q) begin
            holdoff_d = '0;
        end else if (!(&holdoff_q)) begin
            holdoff_d = holdoff_q + 1'b1;
        end
        send_ok = (&holdoff_q) && !uart_busy_i && !wr_q;
        unique case (idx_q)
            2'd0:    pix_byte = word_q[31:24];
            2'd1:    pix_byte = word_q[23:16];
            2'd2:    pix_byte = word_q[15:8];
            default: pix_byte = word_q[7:0];
        endcase
    end

    // Holdoff register.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            holdoff_q <= '0;
        end else begin
            holdoff_q <= holdoff_d;
        end
    end

    // Frame sequencer with registered strobe, data, address and status outputs.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            sync_q  <= '0;
            wr_q    <= 1'b0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef THUMB_STREAMER_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i || continuous_i) begin
                        state_q <= S_SYNC;
                        x_q     <= '0;
                        y_q     <= '0;
                        sync_q  <= '0;
                        busy_q  <= 1'b1;
`ifdef THUMB_STREAMER_CSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                S_SYNC: begin
                    if (send_ok) begin
                        wr_q  <= 1'b1;
                        dat_q <= SYNC_BYTE;
                        if (sync_q == S_LAST) begin
                            sync_q  <= '0;
                            state_q <= S_FETCH;
                        end else begin
                            sync_q <= sync_q + 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    word_q  <= rd_q_i;
                    idx_q   <= '0;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (send_ok) begin
                        wr_q  <= 1'b1;
                        dat_q <= pix_byte;
                        idx_q <= idx_q + 1'b1;
`ifdef THUMB_STREAMER_CSUM_EN
                        csum_q <= csum_q ^ pix_byte;
`endif
                        if (idx_q == 2'd3) begin
                            if (x_q == X_LAST && y_q == Y_LAST) begin
`ifdef THUMB_STREAMER_CSUM_EN
                                state_q <= S_CSUM;
`else
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
`endif
                            end else if (x_q == X_LAST) begin
                                x_q     <= '0;
                                y_q     <= y_q + 1'b1;
                                state_q <= S_FETCH;
                            end else begin
                                x_q     <= x_q + 1'b1;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                end
`ifdef THUMB_STREAMER_CSUM_EN
                S_CSUM: begin
                    if (send_ok) begin
                        wr_q    <= 1'b1;
                        dat_q   <= csum_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thumb_uart_streamer.sv
// Scoreboard bench for thumb_uart_streamer: frame model queue, monitor on strobes.
// Expects THUMB_STREAMER_CSUM_EN to match the RTL build.
module tb_thumb_uart_streamer;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int HB = 3;
    localparam int SL = 4;
`ifdef THUMB_STREAMER_CSUM_EN
    localparam int FL = SL + 4 * W * H + 1;
`else
    localparam int FL = SL + 4 * W * H;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic [5:0]  rd_x;
    logic [4:0]  rd_y;
    logic [31:0] rd_q;
    logic        ubusy;
    logic        wr;
    logic [7:0]  dat;
    logic        busy;
    logic        done;

    logic [31:0] ram_seed = '0;
    int          ucnt = 0;
    bit          force_busy = 1'b0;

    always #5 clk = ~clk;

    thumb_uart_streamer #(
        .WIDTH(W), .HEIGHT(H), .HOLDOFF_BITS(HB),
        .SYNC_BYTE(8'hA5), .SYNC_LEN(SL)
    ) dut (
        .sys_clk_i(clk),
        .sys_rst_n_i(rst_n),
        .start_i(start),
        .continuous_i(cont),
        .rd_x_o(rd_x),
        .rd_y_o(rd_y),
        .rd_q_i(rd_q),
        .uart_busy_i(ubusy),
        .uart_wr_o(wr),
        .uart_dat_o(dat),
        .busy_o(busy),
        .frame_done_o(done)
    );

    // Registered-read thumbnail RAM.
    always @(posedge clk)
        rd_q <= (32'h11223344 + 32'(rd_x) + 32'(rd_y) * 16) ^ ram_seed;

    // UART model: busy for 10 cycles after each write.
    always @(posedge clk) begin
        if (wr) ucnt <= 10;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end
    assign ubusy = (ucnt != 0) || force_busy;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_frame(logic [31:0] seed);
        exp_t       e;
        logic [31:0] w;
        logic [7:0]  cs;
        int          n;
        n = 0;
        cs = '0;
        for (int i = 0; i < SL; i++) begin
            n++;
            e.b = 8'hA5;
            e.last = (n == FL);
            q.push_back(e);
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                w = (32'h11223344 + 32'(x) + 32'(16 * y)) ^ seed;
                for (int k = 0; k < 4; k++) begin
                    n++;
                    e.b = 8'((w >> (24 - 8 * k)) & 32'hFF);
                    e.last = (n == FL);
                    cs = cs ^ e.b;
                    q.push_back(e);
                end
            end
        end
`ifdef THUMB_STREAMER_CSUM_EN
        e.b = cs;
        e.last = 1'b1;
        q.push_back(e);
`endif
    endfunction

    int   strobes = 0;
    int   dones = 0;
    int   idle = 0;
    logic prev_wr = 1'b0;
    exp_t m;

    // Monitor: pop expected bytes on every strobe, check pacing and pulses.
    always @(negedge clk) begin
        check("addr_range", 32'(rd_x < W && rd_y < H), 1);
        if (wr) begin
            check("wr_back_to_back", 32'(prev_wr), 0);
            check("holdoff_gap", 32'(idle >= 7), 1);
            strobes++;
            check("strobe_expected", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
                m = q.pop_front();
                check("byte", 32'(dat), 32'(m.b));
                check("frame_done_on_last", 32'(done), 32'(m.last));
            end
            idle = 0;
        end else begin
            check("frame_done_no_strobe", 32'(done), 0);
            if (!ubusy) idle++;
            else idle = 0;
        end
        if (done) dones++;
        prev_wr = wr;
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobes(int target, int budget, string nm);
        int t;
        t = 0;
        while (strobes < target && t < budget) begin
            tick(1);
            t++;
        end
        check(nm, 32'(strobes >= target), 1);
    endtask

    task automatic wait_dones(int target, int budget, string nm);
        int t;
        t = 0;
        while (dones < target && t < budget) begin
            tick(1);
            t++;
        end
        check(nm, 32'(dones >= target), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int s0;
        int sn;

        tick(5);
        check("rst_wr", 32'(wr), 0);
        check("rst_dat", 32'(dat), 0);
        check("rst_x", 32'(rd_x), 0);
        check("rst_y", 32'(rd_y), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick(20);
        check("idle_no_start", 32'(busy), 0);

        ram_seed = '0;
        push_frame('0);
        base = dones;
        pulse_start();
        check("busy_after_start", 32'(busy), 1);
        wait_dones(base + 1, 3000, "frame1_done");
        tick(2);
        check("frame1_busy_low", 32'(busy), 0);
        check("frame1_queue_empty", 32'(q.size()), 0);
        check("frame1_done_count", 32'(dones), 32'(base + 1));

        ram_seed = $urandom;
        push_frame(ram_seed);
        base = dones;
        s0 = strobes;
        pulse_start();
        wait_strobes(s0 + SL + int'($urandom_range(1, 6)), 3000, "pre_force");
        force_busy = 1'b1;
        tick(1);
        sn = strobes;
        tick(49);
        check("no_strobe_while_busy", 32'(strobes), 32'(sn));
        force_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_strobes(s0 + SL + 8 + 2 * i, 3000, "pre_start_ignore");
            pulse_start();
        end
        wait_dones(base + 1, 3000, "frame2_done");
        tick(100);
        check("start_ignored_busy", 32'(busy), 0);
        check("start_ignored_done", 32'(dones), 32'(base + 1));
        check("frame2_queue_empty", 32'(q.size()), 0);

        ram_seed = $urandom;
        push_frame(ram_seed);
        push_frame(ram_seed);
        push_frame(ram_seed);
        base = dones;
        s0 = strobes;
        cont = 1'b1;
        wait_dones(base + 2, 8000, "cont_two_done");
        wait_strobes(s0 + 2 * FL + SL + int'($urandom_range(1, 10)), 3000,
                     "cont_third_mid");
        cont = 1'b0;
        wait_dones(base + 3, 3000, "cont_third_done");
        tick(150);
        check("cont_done_count", 32'(dones), 32'(base + 3));
        check("cont_busy_low", 32'(busy), 0);
        check("cont_queue_empty", 32'(q.size()), 0);

        ram_seed = '0;
        push_frame('0);
        s0 = strobes;
        pulse_start();
        wait_strobes(s0 + SL + 9, 3000, "pixel9");
        rst_n = 1'b0;
        q.delete();
        tick(1);
        rst_n = 1'b1;
        check("mid_rst_wr", 32'(wr), 0);
        check("mid_rst_x", 32'(rd_x), 0);
        check("mid_rst_y", 32'(rd_y), 0);
        check("mid_rst_busy", 32'(busy), 0);
        tick(30);
        check("mid_rst_stays_idle", 32'(busy), 0);
        push_frame('0);
        base = dones;
        pulse_start();
        wait_dones(base + 1, 3000, "restart_done");
        tick(5);
        check("restart_queue_empty", 32'(q.size()), 0);
        check("restart_busy_low", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
